cpu_controller: RTL

- 8-phase instruction sequencer for the RISC-CPU. It sits directly upstream of the main memory and drives that memory's `read_en` and `write_en` strobes and the address-select mux.
- It also drives the load and increment strobes for the IR, PC and accumulator.
- Every instruction takes exactly 8 clocks. Instruction format: opcode[7:5], operand address[4:0].

---
 rtl/cpu_controller.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/cpu_controller.sv
// cpu_controller: 8-phase instruction sequencer for the RISC-CPU.
// Generates the memory strobes, the address-mux select and the
// IR/PC/accumulator load and increment strobes. Each instruction takes
// eight clocks. The opcode is IR[7:5], and the operand address is IR[4:0].
//
// Optional feature: define CPU_CONTROLLER_SINGLE_STEP_EN to add a `step`
// input. The controller then parks in phase 0 after reset and after every
// instruction. It leaves phase 0 only on a clock where step=1 and enable=1.
//
// Strobe semantics: every output is a level decoded combinationally from
// the current phase, opcode and zero. Consumers act on the level during
// the cycle, and there is no handshake back into this block. The `phase`
// output is the FSM state, exposed for debug and checkers.

module cpu_controller #(
    parameter bit HALT_STICKY = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
`ifdef CPU_CONTROLLER_SINGLE_STEP_EN
    input  logic       step,
`endif
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic       sel,
    output logic       read_en,
    output logic       write_en,
    output logic       ld_ir,
    output logic       inc_pc,
    output logic       ld_pc,
    output logic       ld_ac,
    output logic       data_e,
    output logic       halt,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        PH_INST_ADDR  = 3'd0,
        PH_INST_FETCH = 3'd1,
        PH_INST_LOAD  = 3'd2,
        PH_IDLE       = 3'd3,
        PH_OP_ADDR    = 3'd4,
        PH_OP_FETCH   = 3'd5,
        PH_ALU_OP     = 3'd6,
        PH_STORE      = 3'd7
    } phase_t;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    phase_t phase_q, phase_d;
    logic   halted_q, halted_d;
    logic   advance;

    logic is_hlt, is_skz, is_sto, is_jmp, is_aluop;

    assign is_hlt   = (opcode == OP_HLT);
    assign is_skz   = (opcode == OP_SKZ);
    assign is_sto   = (opcode == OP_STO);
    assign is_jmp   = (opcode == OP_JMP);
    assign is_aluop = (opcode == OP_ADD) || (opcode == OP_AND) ||
                      (opcode == OP_XOR) || (opcode == OP_LDA);

    // State register: reset is asynchronous so it can abort an instruction mid-flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q  <= PH_INST_ADDR;
            halted_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            halted_q <= halted_d;
        end
    end

    // Next-state logic: advance one phase per enabled clock. A sticky halt freezes phase 4.
    always_comb begin
        phase_d  = phase_q;
        halted_d = halted_q;
        advance  = enable && !halted_q;
`ifdef CPU_CONTROLLER_SINGLE_STEP_EN
        // Phase 0 is entered only from reset or the 7->0 wrap, so gating
        // here covers both parking points.
        if (phase_q == PH_INST_ADDR && !step) begin
            advance = 1'b0;
        end
`endif
        if (advance) begin
            if (HALT_STICKY && phase_q == PH_OP_ADDR && is_hlt) begin
                // Phase stays at 4. The PC has already been incremented once in this phase.
                halted_d = 1'b1;
            end else begin
                phase_d = phase_t'(phase_q + 3'd1);
            end
        end
    end

    // Output decode: the strobes for each phase. A halted controller raises only halt.
    always_comb begin
        sel      = 1'b0;
        read_en  = 1'b0;
        write_en = 1'b0;
        ld_ir    = 1'b0;
        inc_pc   = 1'b0;
        ld_pc    = 1'b0;
        ld_ac    = 1'b0;
        data_e   = 1'b0;
        halt     = 1'b0;
        if (halted_q) begin
            halt = 1'b1;
        end else begin
            case (phase_q)
                PH_INST_ADDR: begin
                    sel = 1'b1;
                end
                PH_INST_FETCH: begin
                    sel     = 1'b1;
                    read_en = 1'b1;
                end
                PH_INST_LOAD, PH_IDLE: begin
                    sel     = 1'b1;
                    read_en = 1'b1;
                    ld_ir   = 1'b1;
                end
                PH_OP_ADDR: begin
                    inc_pc = 1'b1;
                    halt   = is_hlt;
                end
                PH_OP_FETCH: begin
                    read_en = is_aluop;
                end
                PH_ALU_OP: begin
                    // data_e rises one cycle ahead of write_en so the bus is
                    // settled before the level-sensitive memory write.
                    read_en = is_aluop;
                    inc_pc  = is_skz && zero;
                    ld_pc   = is_jmp;
                    data_e  = is_sto;
                end
                PH_STORE: begin
                    read_en  = is_aluop;
                    ld_ac    = is_aluop;
                    inc_pc   = is_jmp;
                    ld_pc    = is_jmp;
                    data_e   = is_sto;
                    write_en = is_sto;
                end
                default: begin
                    sel = 1'b1;
                end
            endcase
        end
    end

    assign phase = phase_q;

endmodule
